// File: rtl/i2c_burst_master.sv
// ---------------------------------------------------------------------------
// i2c_burst_master
//
// I2C write-burst master. Each accepted command produces one frame:
//   START, {slave_addr, W}, reg_addr, 0..MAX_BYTES payload bytes, STOP.
// Payload bytes are pulled in over a data_valid/data_ready handshake.
// SCL/SDA are open-drain: the *_oe outputs only pull the line low.
//
// Parameters
//   CLK_DIV    clk cycles per quarter SCL period (>= 2)
//   MAX_BYTES  maximum payload bytes per burst (>= 1)
//   CNT_W      width of byte_count
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               command strobe, accepted only when busy = 0
//   slave_addr[6:0]     target address          (latched at accept)
//   reg_addr[7:0]       first register address  (latched at accept)
//   byte_count[CNT_W-1:0] payload length, clamped to MAX_BYTES (latched)
//   data_in[7:0]        payload byte
//   data_valid          data_in is valid
//   data_ready          block requests the next payload byte
//   busy                burst in progress (accept+1 through done)
//   done                one-cycle pulse at end of burst
//   ack_error           a NACK occurred; set with done, held to next accept
//   scl_oe, sda_oe      1 pulls the corresponding line low
//   scl_in, sda_in      line levels (sda_in already synchronised)
//
// Build option
//   I2C_CLK_STRETCH_EN  when defined, the quarter counter waits for
//                       scl_in = 1 after every SCL release, so a slave can
//                       stretch the clock. When undefined scl_in is unused.
// ---------------------------------------------------------------------------
module i2c_burst_master #(
    parameter int CLK_DIV   = 125,
    parameter int MAX_BYTES = 16,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       slave_addr,
    input  logic [7:0]       reg_addr,
    input  logic [CNT_W-1:0] byte_count,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             busy,
    output logic             done,
    output logic             ack_error,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             scl_in,
    input  logic             sda_in
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK_A,
        S_REG,
        S_ACK_R,
        S_FETCH,
        S_DATA,
        S_ACK_D,
        S_STOP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] qcnt;       // clk cycles within the current quarter
    logic [1:0]       phase;      // quarter index within START/bit/STOP
    logic [2:0]       bit_idx;    // bits still to send after the current one
    logic [7:0]       shreg;      // byte being shifted out, MSB first
    logic [7:0]       reg_lat;
    logic [CNT_W-1:0] left;       // payload bytes not yet fetched
    logic             nack;       // NACK seen in this burst

    logic accept;
    logic hold;
    logic tick;
    logic stretch_hold;

    assign accept = start && !busy;

`ifdef I2C_CLK_STRETCH_EN
    // After SCL has been released (phase 2 of a bit or of STOP) the next
    // quarter does not start counting until the line is really high.
    always_comb begin
        stretch_hold = 1'b0;
        if (phase == 2'd2 && !scl_in) begin
            case (state)
                S_ADDR, S_REG, S_DATA,
                S_ACK_A, S_ACK_R, S_ACK_D,
                S_STOP:  stretch_hold = 1'b1;
                default: stretch_hold = 1'b0;
            endcase
        end
    end
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stretch_hold  = 1'b0;
`endif

    // FETCH freezes the quarter counter except in the handshake cycle itself,
    // so a byte offered immediately costs no bus time and each stall cycle
    // adds exactly one clk cycle to the burst.
    assign hold = ((state == S_FETCH) && !data_valid) || stretch_hold;
    assign tick = busy && !hold && (qcnt == DIV_LAST);

    // Quarter-period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt <= '0;
        end else if (accept) begin
            qcnt <= '0;
        end else if (busy && !hold) begin
            qcnt <= (qcnt == DIV_LAST) ? '0 : qcnt + DIV_W'(1);
        end
    end

    // Burst sequencer. Every tick executes the action of the current quarter
    // and advances to the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            reg_lat    <= '0;
            left       <= '0;
            nack       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_error  <= 1'b0;
            data_ready <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy is still high in the done cycle; dropping it here
                    // makes a start in that cycle be ignored.
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy      <= 1'b1;
                        ack_error <= 1'b0;
                        nack      <= 1'b0;
                        shreg     <= {slave_addr, 1'b0};
                        reg_lat   <= reg_addr;
                        left      <= (byte_count > MAX_CNT) ? MAX_CNT : byte_count;
                        phase     <= '0;
                        bit_idx   <= 3'd7;
                        state     <= S_START;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (phase == 2'd0) begin
                            sda_oe <= 1'b1;
                            phase  <= 2'd1;
                        end else begin
                            scl_oe  <= 1'b1;
                            phase   <= 2'd0;
                            bit_idx <= 3'd7;
                            state   <= S_ADDR;
                        end
                    end
                end

                S_ADDR, S_REG, S_DATA: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: sda_oe <= ~shreg[7];
                            2'd1: scl_oe <= 1'b0;
                            2'd2: ;
                            default: begin
                                scl_oe <= 1'b1;
                                if (bit_idx == 3'd0) begin
                                    case (state)
                                        S_ADDR:  state <= S_ACK_A;
                                        S_REG:   state <= S_ACK_R;
                                        default: state <= S_ACK_D;
                                    endcase
                                end else begin
                                    shreg   <= {shreg[6:0], 1'b0};
                                    bit_idx <= bit_idx - 3'd1;
                                end
                            end
                        endcase
                    end
                end

                S_ACK_A, S_ACK_R, S_ACK_D: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: sda_oe <= 1'b0;
                            2'd1: scl_oe <= 1'b0;
                            2'd2: begin
                                if (sda_in) begin
                                    nack <= 1'b1;
                                end
                            end
                            default: begin
                                scl_oe <= 1'b1;
                                if (nack) begin
                                    state <= S_STOP;
                                end else if (state == S_ACK_A) begin
                                    shreg   <= reg_lat;
                                    bit_idx <= 3'd7;
                                    state   <= S_REG;
                                end else if (left == '0) begin
                                    state <= S_STOP;
                                end else begin
                                    data_ready <= 1'b1;
                                    state      <= S_FETCH;
                                end
                            end
                        endcase
                    end
                end

                S_FETCH: begin
                    // data_ready is high throughout this state
                    if (data_valid) begin
                        shreg      <= data_in;
                        data_ready <= 1'b0;
                        left       <= left - CNT_W'(1);
                        bit_idx    <= 3'd7;
                        phase      <= 2'd0;
                        state      <= S_DATA;
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: begin
                                sda_oe <= 1'b1;
                                scl_oe <= 1'b1;
                            end
                            2'd1: scl_oe <= 1'b0;
                            default: begin
                                sda_oe    <= 1'b0;
                                done      <= 1'b1;
                                ack_error <= nack;
                                phase     <= 2'd0;
                                state     <= S_IDLE;
                            end
                        endcase
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_burst_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_burst_master
//
// Drives write bursts into i2c_burst_master with a behavioural open-drain bus
// and I2C slave. Header and payload bytes are queued as expected bus bytes
// when they are offered to the DUT; the bus monitor pops and compares each
// byte it decodes.
// ---------------------------------------------------------------------------
module tb_i2c_burst_master;

    localparam int CLK_DIV   = 5;
    localparam int MAX_BYTES = 16;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [6:0]       slave_addr;
    logic [7:0]       reg_addr;
    logic [CNT_W-1:0] byte_count;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             done;
    logic             ack_error;
    logic             scl_oe;
    logic             sda_oe;
    logic             scl_line;
    logic             sda_line;
    logic             slave_low;

    assign scl_line = ~scl_oe;
    assign sda_line = ~sda_oe & ~slave_low;

    i2c_burst_master #(
        .CLK_DIV  (CLK_DIV),
        .MAX_BYTES(MAX_BYTES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .slave_addr(slave_addr),
        .reg_addr  (reg_addr),
        .byte_count(byte_count),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_line),
        .sda_in    (sda_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] MY_ADDR = 7'h6A;

    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_q[$];
    logic [7:0] src_q[$];
    int         nack_idx = -1;
    int         stall_len = 0;
    int         ready_rises = 0;
    int         taken = 0;
    int         stop_cnt = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    // ---------------- bus monitor + slave ----------------
    logic       prev_scl, prev_sda, ack_next;
    logic [7:0] mon_sh;
    int         bit_cnt, byte_idx;

    always @(posedge clk) begin
        if (!rst_n) begin
            prev_scl  <= 1'b1;
            prev_sda  <= 1'b1;
            bit_cnt   <= 0;
            byte_idx  <= 0;
            slave_low <= 1'b0;
            ack_next  <= 1'b0;
            mon_sh    <= '0;
        end else begin
            prev_scl <= scl_line;
            prev_sda <= sda_line;
            if (prev_scl && scl_line && prev_sda && !sda_line) begin
                bit_cnt   <= 0;
                byte_idx  <= 0;
                slave_low <= 1'b0;
            end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
                bit_cnt   <= 0;
                slave_low <= 1'b0;
                stop_cnt  <= stop_cnt + 1;
                check_eq("stop_with_all_bytes_sent", exp_q.size(), 0);
            end else if (!prev_scl && scl_line) begin
                if (bit_cnt < 8) mon_sh <= {mon_sh[6:0], sda_line};
                if (bit_cnt == 7) begin
                    check_eq("bus_byte", int'({mon_sh[6:0], sda_line}), pop_exp());
                    ack_next <= (byte_idx == 0) ? (mon_sh[6:0] == MY_ADDR && !sda_line)
                                                : (byte_idx != nack_idx);
                end
                bit_cnt <= bit_cnt + 1;
            end else if (prev_scl && !scl_line) begin
                if (bit_cnt == 8) begin
                    slave_low <= ack_next;
                end else if (bit_cnt == 9) begin
                    slave_low <= 1'b0;
                    bit_cnt   <= 0;
                    byte_idx  <= byte_idx + 1;
                end
            end
        end
    end

    // ---------------- payload source ----------------
    initial begin
        logic ready_q;
        int   wait_cnt;
        logic scl_hi_seen;
        ready_q     = 1'b0;
        wait_cnt    = 0;
        scl_hi_seen = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ready_q    = 1'b0;
                wait_cnt   = 0;
                data_valid = 1'b0;
            end else begin
                if (data_valid && ready_q) begin
                    exp_q.push_back(int'(src_q.pop_front()));
                    taken++;
                    if (stall_len > 0) check_eq("scl_low_during_stall", scl_hi_seen, 0);
                end
                if (data_ready && !ready_q) begin
                    ready_rises++;
                    wait_cnt    = stall_len;
                    scl_hi_seen = 1'b0;
                end
                if (data_ready && scl_line) scl_hi_seen = 1'b1;
                ready_q = data_ready;
                if (wait_cnt > 0) begin
                    data_valid = 1'b0;
                    wait_cnt--;
                end else begin
                    data_valid = (src_q.size() > 0);
                end
                data_in = (src_q.size() > 0) ? src_q[0] : 8'h00;
            end
        end
    end

    // ---------------- command driver ----------------
    task automatic run_cmd(input logic [6:0] sa, input logic [7:0] ra,
                           input logic [CNT_W-1:0] n, input int exp_cyc,
                           input int exp_err, input int exp_rdy,
                           input int exp_taken, input int poke_at);
        int cyc, rdy0, tk0, st0;
        @(negedge clk);
        rdy0 = ready_rises;
        tk0  = taken;
        st0  = stop_cnt;
        exp_q.push_back(int'({sa, 1'b0}));
        if (sa == MY_ADDR) exp_q.push_back(int'(ra));
        slave_addr = sa;
        reg_addr   = ra;
        byte_count = n;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_accept", busy, 1);
        cyc = 0;
        while (!done && cyc < exp_cyc + 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke_at > 0 && cyc == poke_at) begin
                slave_addr = 7'h11;
                start      = 1'b1;
            end
        end
        start      = 1'b0;
        slave_addr = sa;
        check_eq("done_latency", cyc, exp_cyc);
        check_eq("ack_error_at_done", ack_error, exp_err);
        start = 1'b1;   // offered in the done cycle, must be ignored
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_done", busy, 0);
        repeat (4) @(negedge clk);
        check_eq("ack_error_held", ack_error, exp_err);
        check_eq("stop_count", stop_cnt - st0, 1);
        check_eq("data_ready_rises", ready_rises - rdy0, exp_rdy);
        check_eq("bytes_taken", taken - tk0, exp_taken);
        check_eq("bytes_unsent", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        slave_addr = '0;
        reg_addr   = '0;
        byte_count = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", int'({scl_oe, sda_oe, busy, done, ack_error, data_ready}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Burst of 10, slave ACKs everything
        for (int i = 17; i <= 26; i++) src_q.push_back(8'(i));
        run_cmd(7'h6A, 8'h01, 5'd10, (5 + 36 * 12) * CLK_DIV, 0, 10, 10, 0);

        // Address NACK: only the address byte appears, no fetch
        run_cmd(7'h6B, 8'h01, 5'd2, 41 * CLK_DIV, 1, 0, 0, 0);

        // Data NACK on the 3rd payload byte (frame byte index 4)
        nack_idx = 4;
        for (int i = 0; i < 5; i++) src_q.push_back(8'hA0 + 8'(i));
        run_cmd(7'h6A, 8'h10, 5'd5, (41 + 36 * 4) * CLK_DIV, 1, 3, 3, 0);
        src_q.delete();
        nack_idx = -1;

        // Backpressure: 40 stall cycles at each of 3 fetches
        stall_len = 40;
        src_q.push_back(8'h55);
        src_q.push_back(8'hAA);
        src_q.push_back(8'h0F);
        run_cmd(7'h6A, 8'h05, 5'd3, (5 + 36 * 5) * CLK_DIV + 120, 0, 3, 3, 0);
        stall_len = 0;

        // N = 0, with a start pulse while busy
        run_cmd(7'h6A, 8'h0A, 5'd0, (5 + 36 * 2) * CLK_DIV, 0, 0, 0, 100);

        // Clamp: byte_count = MAX_BYTES + 3 sends MAX_BYTES bytes
        for (int i = 0; i < MAX_BYTES + 3; i++) src_q.push_back(8'(i * 7 + 3));
        run_cmd(7'h6A, 8'h20, 5'(MAX_BYTES + 3), (5 + 36 * (MAX_BYTES + 2)) * CLK_DIV,
                0, MAX_BYTES, MAX_BYTES, 0);
        src_q.delete();

        // Reset in the middle of the REG byte
        @(negedge clk);
        exp_q.push_back(int'({7'h6A, 1'b0}));
        slave_addr = 7'h6A;
        reg_addr   = 8'h02;
        byte_count = 5'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (45 * CLK_DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid_burst_outputs",
                 int'({scl_oe, sda_oe, busy, done, ack_error, data_ready}), 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        src_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        src_q.push_back(8'h3C);
        src_q.push_back(8'hC3);
        run_cmd(7'h6A, 8'h03, 5'd2, (5 + 36 * 4) * CLK_DIV, 0, 2, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
